// File: rtl/bp_stream_pump_in_mc_pkg.sv
// Shared types and helpers for the multi-channel stream pumps.
// Holds the mem header layout, address modes and beat-count helper.
package bp_stream_pump_in_mc_pkg;

  localparam int paddr_width_gp = 40;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic {
    e_stream_wrap,
    e_stream_linear
  } stream_addr_mode_e;

  typedef enum logic {
    e_pump_idle,
    e_pump_stream
  } pump_state_e;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [2:0]                size;
    logic [paddr_width_gp-1:0] addr;
  } bp_bedrock_mem_header_s;

  // Payloads larger than a block fold back into the block.
  function automatic int unsigned stream_beats(
    input logic [2:0]  size,
    input int unsigned beat_bytes,
    input int unsigned max_beats
  );
    int unsigned b;
    b = (32'd1 << size) / beat_bytes;
    if (b == 0) b = 1;
    if (b > max_beats) b = max_beats;
    return b;
  endfunction

endpackage

// File: rtl/bp_stream_pump_in_mc_addr_gen.sv
// Beat address generator: wrap (critical-word-first) or linear
// within a block; never carries past the block boundary.
module bp_stream_pump_in_mc_addr_gen
  import bp_stream_pump_in_mc_pkg::*;
#(
  parameter int stream_data_width_p = 64,
  parameter int block_width_p = 512,
  localparam int bo = $clog2(stream_data_width_p / 8),
  localparam int wl = $clog2(block_width_p / stream_data_width_p)
) (
  input  logic [paddr_width_gp-1:0] base,
  input  logic [wl-1:0]             beat,
  input  logic [wl:0]               beats,
  input  stream_addr_mode_e         mode,
  output logic [paddr_width_gp-1:0] addr
);

  logic [wl-1:0] first;
  logic [wl-1:0] mask;
  logic [wl-1:0] word;

  assign first = base[bo +: wl];
  assign mask  = wl'(beats - 1'b1);

  always_comb begin
    word = first + beat;
    if (mode == e_stream_wrap) begin
      word = (first & ~mask) | ((first + beat) & mask);
    end
    addr = base;
    addr[bo +: wl] = word;
  end

endmodule

// File: rtl/bp_stream_pump_in_mc.sv
// Multi-channel inbound stream pump: buffers N mem streams,
// arbitrates round-robin and emits addressed beats to an FSM.
module bp_stream_pump_in_mc
  import bp_stream_pump_in_mc_pkg::*;
#(
  parameter int num_chan_p = 2,
  parameter int stream_data_width_p = 64,
  parameter int block_width_p = 512,
  parameter int buffer_els_p = 2,
  parameter logic [15:0] stream_mask_p = '0,
  parameter logic [15:0] wrap_mask_p = '1,
  localparam int hdr_w = $bits(bp_bedrock_mem_header_s),
  localparam int cw = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int dw = stream_data_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [num_chan_p*hdr_w-1:0]     mem_header_i,
  input  logic [num_chan_p*dw-1:0]        mem_data_i,
  input  logic [num_chan_p-1:0]           mem_v_i,
  input  logic [num_chan_p-1:0]           mem_last_i,
  output logic [num_chan_p-1:0]           mem_ready_and_o,
  output bp_bedrock_mem_header_s          fsm_base_header_o,
  output logic [paddr_width_gp-1:0]       fsm_addr_o,
  output logic [dw-1:0]                   fsm_data_o,
  output logic [cw-1:0]                   fsm_chan_o,
  output logic                            fsm_v_o,
  input  logic                            fsm_ready_and_i,
  output logic                            stream_new_o,
  output logic                            stream_done_o,
  output logic                            protocol_err_o
);

  localparam int wl = $clog2(block_width_p / dw);
  localparam int nbw = wl + 1;
  localparam int ew = $clog2(buffer_els_p);
  localparam int cntw = $clog2(buffer_els_p + 1);
  localparam int max_beats = block_width_p / dw;

  bp_bedrock_mem_header_s hq [num_chan_p][buffer_els_p];
  logic [dw-1:0]          dq [num_chan_p][buffer_els_p];
  logic                   lq [num_chan_p][buffer_els_p];
  logic [ew-1:0]          rp [num_chan_p];
  logic [ew-1:0]          wp [num_chan_p];
  logic [cntw-1:0]        cnt [num_chan_p];

  logic                  ready_en;
  logic [num_chan_p-1:0] full, nonempty, enq, pop;

  pump_state_e            state, state_n;
  logic [cw-1:0]          rr, lock, pick, sel, idx;
  logic                   stall, found;
  logic [wl-1:0]          k;
  bp_bedrock_mem_header_s held, head_hdr, cur;
  logic [dw-1:0]          head_data;
  logic                   head_last;
  logic [nbw-1:0]         nb;
  logic                   streamed, final_beat, v, accept;
  stream_addr_mode_e      mode;

  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      full[c]     = cnt[c] == cntw'(buffer_els_p);
      nonempty[c] = cnt[c] != '0;
    end
  end

  assign mem_ready_and_o = {num_chan_p{ready_en}} & ~full;
  assign enq = mem_v_i & mem_ready_and_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en <= 1'b0;
      for (int c = 0; c < num_chan_p; c++) begin
        rp[c]  <= '0;
        wp[c]  <= '0;
        cnt[c] <= '0;
        for (int e = 0; e < buffer_els_p; e++) begin
          hq[c][e] <= '0;
          dq[c][e] <= '0;
          lq[c][e] <= 1'b0;
        end
      end
    end else begin
      ready_en <= 1'b1;
      for (int c = 0; c < num_chan_p; c++) begin
        if (enq[c]) begin
          hq[c][wp[c]] <= mem_header_i[c*hdr_w +: hdr_w];
          dq[c][wp[c]] <= mem_data_i[c*dw +: dw];
          lq[c][wp[c]] <= mem_last_i[c];
          wp[c] <= (wp[c] == ew'(buffer_els_p - 1)) ? '0 : wp[c] + 1'b1;
        end
        if (pop[c]) begin
          rp[c] <= (rp[c] == ew'(buffer_els_p - 1)) ? '0 : rp[c] + 1'b1;
        end
        cnt[c] <= cnt[c] + cntw'(enq[c]) - cntw'(pop[c]);
      end
    end
  end

  always_comb begin
    pick  = rr;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < num_chan_p; i++) begin
      idx = cw'((int'(rr) + i) % num_chan_p);
      if (!found && nonempty[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // A presented beat keeps its grant until taken, so stalls stay stable.
  assign sel = (state == e_pump_stream || stall) ? lock : pick;

  assign head_hdr  = hq[sel][rp[sel]];
  assign head_data = dq[sel][rp[sel]];
  assign head_last = lq[sel][rp[sel]];
  assign cur = (state == e_pump_stream) ? held : head_hdr;

  assign nb = nbw'(stream_beats(cur.size, dw / 8, max_beats));
  assign streamed = stream_mask_p[cur.msg_type] && (nb > nbw'(1));
  assign mode = wrap_mask_p[cur.msg_type] ? e_stream_wrap : e_stream_linear;
  assign final_beat = !streamed || (k == wl'(nb - 1'b1));

  assign v = nonempty[sel];
  assign accept = v && fsm_ready_and_i;

  always_comb begin
    pop = '0;
    pop[sel] = accept;
  end

  bp_stream_pump_in_mc_addr_gen #(
    .stream_data_width_p(dw),
    .block_width_p(block_width_p)
  ) addr_gen (
    .base (cur.addr),
    .beat (k),
    .beats(nb),
    .mode (mode),
    .addr (fsm_addr_o)
  );

  assign fsm_base_header_o = cur;
  assign fsm_data_o = head_data;
  assign fsm_chan_o = sel;
  assign fsm_v_o = v;
  assign stream_new_o = v && streamed && (state == e_pump_idle);
  assign stream_done_o = accept && final_beat;
  assign protocol_err_o = accept && (head_last != final_beat);

  always_comb begin
    state_n = state;
    unique case (state)
      e_pump_idle:   if (accept && !final_beat) state_n = e_pump_stream;
      e_pump_stream: if (accept && final_beat) state_n = e_pump_idle;
      default:       state_n = e_pump_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= e_pump_idle;
      rr    <= '0;
      lock  <= '0;
      stall <= 1'b0;
      k     <= '0;
      held  <= '0;
    end else begin
      state <= state_n;
      if (v && !fsm_ready_and_i) begin
        stall <= 1'b1;
        lock  <= sel;
      end
      if (accept) begin
        stall <= 1'b0;
        lock  <= sel;
        k     <= final_beat ? '0 : k + 1'b1;
        if (state == e_pump_idle) held <= head_hdr;
      end
      if (stream_done_o) begin
        rr <= (sel == cw'(num_chan_p - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule
